// File: rtl/irq_controller.sv
// Four-source interrupt controller for the KCPU register file.
// Define IRQ_ROUND_ROBIN_EN for round-robin arbitration (default fixed).
module irq_controller #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              irqValid,
  input  logic [4*DATA_WIDTH-1:0] irqData,
  output logic [3:0]              irqReady,
  input  logic                    cpuMode,
  input  logic                    modeSwitch,
  input  logic                    setDivisionBy0,
  output logic                    setHardwareInterrupt,
  output logic [1:0]              hardwareInterruptType,
  output logic [DATA_WIDTH-1:0]   hardwareInterruptData,
  output logic [3:0]              pending,
  output logic                    inHandler
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ENTER,
    WAIT_RETURN
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_pending;
  logic [DATA_WIDTH-1:0] r_data [4];
  logic                  r_set;
  logic [1:0]            r_type;
  logic [DATA_WIDTH-1:0] r_out;

  logic                  w_fire;
  logic [1:0]            w_win;
  logic [3:0]            w_clr;
  logic [3:0]            w_cap;
  logic [3:0]            w_pend_nxt;

  assign w_fire = (r_state == IDLE) && (|r_pending) && cpuMode
                  && !modeSwitch && !setDivisionBy0;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [1:0] r_last;

  // Nearest pending slot after the last grant wins.
  always_comb begin
    w_win = r_last;
    for (int k = 3; k >= 0; k--) begin
      if (r_pending[2'(r_last + 2'(k) + 2'd1)])
        w_win = 2'(r_last + 2'(k) + 2'd1);
    end
  end

  // Last-granted pointer, reset to 3 so slot 0 is searched first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_last <= 2'd3;
    else if (w_fire)
      r_last <= w_win;
  end
`else
  // Fixed priority: lowest pending index wins.
  always_comb begin
    w_win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r_pending[i])
        w_win = 2'(i);
    end
  end
`endif

  // Slot flags: winner cleared on fire, empty slots capture.
  always_comb begin
    w_clr      = w_fire ? (4'b0001 << w_win) : 4'b0000;
    w_cap      = irqValid & ~r_pending;
    w_pend_nxt = (r_pending & ~w_clr) | w_cap;
  end

  // Pending flags and payload latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= 4'b0000;
      for (int i = 0; i < 4; i++)
        r_data[i] <= '0;
    end else begin
      r_pending <= w_pend_nxt;
      for (int i = 0; i < 4; i++) begin
        if (w_cap[i])
          r_data[i] <= irqData[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Handler-tracking next state.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:        if (w_fire) w_next = WAIT_ENTER;
      WAIT_ENTER:  if (!cpuMode) w_next = WAIT_RETURN;
      WAIT_RETURN: if (cpuMode && !modeSwitch) w_next = IDLE;
      default:     w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // Registered delivery pulse; type/data hold between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_set  <= 1'b0;
      r_type <= 2'd0;
      r_out  <= '0;
    end else begin
      r_set <= w_fire;
      if (w_fire) begin
        r_type <= w_win;
        r_out  <= r_data[w_win];
      end
    end
  end

  assign irqReady              = ~r_pending;
  assign pending               = r_pending;
  assign setHardwareInterrupt  = r_set;
  assign hardwareInterruptType = r_type;
  assign hardwareInterruptData = r_out;
  assign inHandler             = (r_state != IDLE);

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller.
// Deliveries are checked against a queue filled as requests are driven.
module tb_irq_controller;

  logic         clk;
  logic         rst;
  logic [3:0]   irqValid;
  logic [127:0] irqData;
  logic [3:0]   irqReady;
  logic         cpuMode;
  logic         modeSwitch;
  logic         setDivisionBy0;
  logic         setHardwareInterrupt;
  logic [1:0]   hardwareInterruptType;
  logic [31:0]  hardwareInterruptData;
  logic [3:0]   pending;
  logic         inHandler;

  typedef struct {
    logic [1:0]  t;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pulses = 0;
  int   p;
  bit   rr;

  irq_controller #(.DATA_WIDTH(32)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .irqValid              (irqValid),
    .irqData               (irqData),
    .irqReady              (irqReady),
    .cpuMode               (cpuMode),
    .modeSwitch            (modeSwitch),
    .setDivisionBy0        (setDivisionBy0),
    .setHardwareInterrupt  (setHardwareInterrupt),
    .hardwareInterruptType (hardwareInterruptType),
    .hardwareInterruptData (hardwareInterruptData),
    .pending               (pending),
    .inHandler             (inHandler)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] t, input logic [31:0] d);
    exp_t e;
    e.t = t;
    e.d = d;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exit_handler();
    cpuMode = 1'b0;
    step();
    cpuMode = 1'b1;
    step();
  endtask

  // Delivery monitor: pops the scoreboard on every pulse.
  initial begin
    exp_t e;
    bit   prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && setHardwareInterrupt) begin
        n_pulses++;
        check("pulse_width", prev, 0);
        check("sb_has_entry", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("irq_type", hardwareInterruptType, e.t);
          check("irq_data", hardwareInterruptData, e.d);
        end
      end
      prev = setHardwareInterrupt;
    end
  end

  initial begin
`ifdef IRQ_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    rst            = 1'b0;
    cpuMode        = 1'b1;
    modeSwitch     = 1'b0;
    setDivisionBy0 = 1'b0;
    irqValid       = 4'b0000;
    irqData        = '0;
    step();
    step();
    check("rst_ready", irqReady, 4'hF);
    check("rst_pending", pending, 0);
    check("rst_set", setHardwareInterrupt, 0);
    check("rst_type", hardwareInterruptType, 0);
    check("rst_data", hardwareInterruptData, 0);
    check("rst_inh", inHandler, 0);
    rst = 1'b1;
    repeat (5) step();
    check("idle_nopulse", n_pulses, 0);

    // single delivery from source 2
    irqValid = 4'b0100;
    irqData[64 +: 32] = 32'hDEADBEEF;
    push(2'd2, 32'hDEADBEEF);
    step();
    check("cap_pending", pending, 4'b0100);
    check("cap_ready", irqReady, 4'b1011);
    irqValid = 4'b0000;
    step();
    check("fire_set", setHardwareInterrupt, 1);
    check("fire_type", hardwareInterruptType, 2);
    check("fire_data", hardwareInterruptData, 32'hDEADBEEF);
    check("fire_inh", inHandler, 1);
    check("fire_clr", pending, 0);
    step();
    check("pulse_fall", setHardwareInterrupt, 0);
    check("enter_inh", inHandler, 1);

    // handler tracking: source 0 waits for the return
    irqValid = 4'b0001;
    irqData[0 +: 32] = 32'h11110000;
    push(2'd0, 32'h11110000);
    step();
    check("hnd_pending", pending, 4'b0001);
    irqValid = 4'b0000;
    p = n_pulses;
    repeat (3) step();
    check("hnd_enter_hold", n_pulses, p);
    cpuMode = 1'b0;
    step();
    step();
    check("hnd_ret_inh", inHandler, 1);
    check("hnd_ret_pend", pending, 4'b0001);
    cpuMode    = 1'b1;
    modeSwitch = 1'b1;
    step();
    check("hnd_ms_hold", inHandler, 1);
    modeSwitch = 1'b0;
    step();
    check("hnd_idle", inHandler, 0);
    check("hnd_idle_set", setHardwareInterrupt, 0);
    step();
    check("hnd_deliver", setHardwareInterrupt, 1);
    check("hnd_type", hardwareInterruptType, 0);

    // arbitration between sources 1 and 3
    irqValid = 4'b1010;
    irqData[32 +: 32] = 32'hA1A10001;
    irqData[96 +: 32] = 32'hC3C30003;
    push(2'd1, 32'hA1A10001);
    if (rr) push(2'd3, 32'hC3C30003);
    step();
    check("arb_pending", pending, 4'b1010);
    irqValid = 4'b0000;
    exit_handler();
    step();
    check("arb_first_set", setHardwareInterrupt, 1);
    check("arb_first", hardwareInterruptType, 1);
    irqValid = 4'b0010;
    irqData[32 +: 32] = 32'hB1B10001;
    if (rr) begin
      push(2'd1, 32'hB1B10001);
    end else begin
      push(2'd1, 32'hB1B10001);
      push(2'd3, 32'hC3C30003);
    end
    step();
    check("arb_repend", pending, 4'b1010);
    irqValid = 4'b0000;
    exit_handler();
    step();
    check("arb_second_set", setHardwareInterrupt, 1);
    check("arb_second", hardwareInterruptType, rr ? 3 : 1);
    exit_handler();
    step();
    check("arb_third_set", setHardwareInterrupt, 1);
    check("arb_third", hardwareInterruptType, rr ? 1 : 3);
    check("arb_empty", pending, 0);

    // blocking conditions
    exit_handler();
    modeSwitch = 1'b1;
    irqValid = 4'b0001;
    irqData[0 +: 32] = 32'h0B0B0B0B;
    push(2'd0, 32'h0B0B0B0B);
    step();
    check("blk_pending", pending, 4'b0001);
    irqValid = 4'b0000;
    p = n_pulses;
    repeat (3) step();
    check("blk_modesw", n_pulses, p);
    modeSwitch     = 1'b0;
    setDivisionBy0 = 1'b1;
    repeat (3) step();
    check("blk_div0", n_pulses, p);
    setDivisionBy0 = 1'b0;
    cpuMode        = 1'b0;
    repeat (3) step();
    check("blk_supv", n_pulses, p);
    check("blk_still_pend", pending, 4'b0001);
    cpuMode = 1'b1;
    step();
    check("blk_release", setHardwareInterrupt, 1);

    // full slots, then reset while in WAIT_RETURN
    irqValid = 4'hF;
    irqData  = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000001};
    step();
    check("full_pending", pending, 4'hF);
    check("full_ready", irqReady, 4'h0);
    irqValid = 4'b0000;
    cpuMode  = 1'b0;
    step();
    check("full_inh", inHandler, 1);
    #3;
    rst = 1'b0;
    #1;
    check("mrst_pending", pending, 0);
    check("mrst_ready", irqReady, 4'hF);
    check("mrst_inh", inHandler, 0);
    check("mrst_set", setHardwareInterrupt, 0);
    check("mrst_data", hardwareInterruptData, 0);
    rst = 1'b1;
    cpuMode = 1'b1;
    p = n_pulses;
    repeat (4) step();
    check("post_rst_nopulse", n_pulses, p);
    check("sb_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Hardware interrupt controller for the KCPU register file. Accepts interrupt requests from up to four peripheral sources, buffers one request per source, and arbitrates among pending requests. It delivers the winner to the register file's `setHardwareInterrupt`, `hardwareInterruptType` and `hardwareInterruptData` inputs, but only when the CPU is in user mode and can take it. It then tracks the supervisor handler until the CPU returns to user mode before delivering the next interrupt.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of the interrupt payload written to uR2.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `irqValid`  in  4  per-source request valid.
- `irqData`  in  4*DATA_WIDTH  per-source payload; source i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- `irqReady`  out  4  per-source slot empty, equal to !pending[i].
- `cpuMode`  in  1  from register file: 0 = supervisor, 1 = user.
- `modeSwitch`  in  1  from register file: mode switch in progress.
- `setDivisionBy0`  in  1  division-by-0 interrupt firing this cycle.
- `setHardwareInterrupt`  out  1  registered one-cycle delivery pulse to the register file.
- `hardwareInterruptType`  out  2  winning source index.
- `hardwareInterruptData`  out  DATA_WIDTH  winning payload.
- `pending`  out  4  slot-occupied flags.
- `inHandler`  out  1  high in WAIT_ENTER and WAIT_RETURN.

## Operation
- Capture:
  - A request is captured into slot i on the edge where `irqValid[i] && irqReady[i]`. This sets pending[i] and latches the payload.
  - A source must hold `irqValid` and `irqData` stable until it sees `irqReady` high.
- FSM states:
  - **IDLE**
    - Fires when `pending != 0 && cpuMode && !modeSwitch && !setDivisionBy0`.
    - On the firing edge: register `setHardwareInterrupt` = 1, register type and data of the winner, clear the winner's slot, and go to WAIT_ENTER.
    - Otherwise stay in IDLE.
  - **WAIT_ENTER**
    - `setHardwareInterrupt` returns to 0 after exactly one cycle.
    - Go to WAIT_RETURN when `cpuMode == 0`.
  - **WAIT_RETURN**
    - Go to IDLE when `cpuMode == 1 && !modeSwitch`.
    - The earliest next delivery is the cycle after re-entering IDLE.
- Arbitration: fixed priority by default, source 0 highest. The winner is computed from the pending flags as they stand in IDLE.
- `hardwareInterruptType` and `hardwareInterruptData` hold their last delivered value between pulses.
- Captures continue in every state, including the slot cleared on the firing edge: the cleared slot's `irqReady` is high from the next cycle.
- Boundary conditions:
  - Simultaneous capture and fire on different slots: both take effect on the same edge.
  - Fire condition true but `setDivisionBy0` high: no delivery; retry next cycle.
  - `cpuMode` already 0 in IDLE: no delivery; pending requests wait.
  - All four slots full: all `irqReady` low; sources stall.

## Timing
- Reset (async, `rst` low) gives:
  - FSM in IDLE.
  - pending = 0, `irqReady` = 4'b1111.
  - `setHardwareInterrupt` = 0, type = 0, data = 0.
  - `inHandler` = 0.
- Latency:
  - Capture to `pending` visible: 1 cycle.
  - Pending in IDLE with the condition true to `setHardwareInterrupt` high: 1 cycle, because the output is registered.
  - Minimum best-case source-valid to delivery: 2 cycles.
- The pulse width of `setHardwareInterrupt` is exactly 1 cycle in all cases.
- Reset asserted mid-handler drops all pending requests and returns the FSM to IDLE immediately.

## Configuration
- `IRQ_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration.
  - A 2-bit last-granted pointer is updated on each delivery.
  - Search starts at last+1 and wraps modulo 4.
  - The pointer resets to 3, so source 0 wins first.
- `IRQ_ROUND_ROBIN_EN` undefined: fixed priority with source 0 highest; no pointer register.

## Test plan
- Reset behaviour: drive `rst` low with `cpuMode`=1 -> all outputs at reset values and `irqReady`=4'hF; release, idle 5 cycles -> no pulse.
- Single delivery: `cpuMode`=1, source 2 sends 32'hDEADBEEF -> pending=4'b0100 next cycle; on the following cycle `setHardwareInterrupt`=1 for one cycle with type=2 and data=32'hDEADBEEF; `inHandler`=1.
- Handler tracking: during WAIT_ENTER/WAIT_RETURN, source 0 request is captured but not delivered; drop `cpuMode` to 0, then raise it with `modeSwitch`=0 -> source 0 delivered 2 cycles after the return.
- Arbitration: sources 1 and 3 pending simultaneously.
  - Fixed priority: order 1 then 3.
  - With `IRQ_ROUND_ROBIN_EN`, after a prior grant to 1, sources 1 and 3 re-pending -> 3 wins next.
- Blocking conditions: pending=4'b0001 with `modeSwitch`=1, then with `setDivisionBy0`=1, then with `cpuMode`=0 -> no pulse in any of these; clearing all three gives a pulse 1 cycle later.
- Full and mid-reset: fill all 4 slots -> `irqReady`=0; assert `rst` while in WAIT_RETURN -> pending=0 and FSM in IDLE asynchronously.
